// File: rtl/post_period_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : post_period_pkg
//  Description : Shared definitions for the post-period display block.
//                Holds the state encodings, the active-low 7-segment
//                constants ({dp,g,f,e,d,c,b,a}), the digit table and the
//                default display duration.
//  Revision    : 1.0  initial release
// ============================================================================
package post_period_pkg;

  // State encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Segment patterns are active-low; dp is always off
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Default number of 1 Hz ticks the count stays on display
  localparam int POST_SECONDS_DEFAULT = 5;

  // Digit table: BCD digit to active-low segment pattern.
  // Codes 10..15 never occur for valid BCD and map to blank.
  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_decoder
//  Description : Converts one BCD digit to an active-low 7-segment pattern,
//                with a blank override.
//  Ports       : bcd_i   [3:0] BCD digit
//                blank_i       1 = force all segments off
//                seg_o   [7:0] active-low pattern {dp,g,f,e,d,c,b,a}
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_decoder
  import post_period_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : seg_digit(bcd_i);

endmodule
`default_nettype wire

// File: rtl/post_period.sv
`default_nettype none
// ============================================================================
//  Module      : post_period
//  Description : End-of-level post period. A postSig pulse latches the final
//                magic-symbol count, which is shown in decimal for
//                POST_SECONDS ticks of the 1 Hz enable; levelComplete then
//                pulses for one cycle.
//  Ports       : Clk100M            system clock (rising edge)
//                Reset              asynchronous active-high reset
//                Clk1Hz             one-cycle enable, once per second
//                postSig            one-cycle start pulse
//                magicSymbolCount   [7:0] count to display
//                levelComplete      one-cycle end-of-period pulse
//                postSeg0..postSeg3 [7:0] ones, tens, hundreds, blank digit
//  Revision    : 1.0  initial release
// ============================================================================
module post_period
  import post_period_pkg::*;
#(
  parameter int POST_SECONDS = POST_SECONDS_DEFAULT
)(
  input  logic       Clk100M,
  input  logic       Reset,
  input  logic       Clk1Hz,
  input  logic       postSig,
  input  logic [7:0] magicSymbolCount,
  output logic       levelComplete,
  output logic [7:0] postSeg0,
  output logic [7:0] postSeg1,
  output logic [7:0] postSeg2,
  output logic [7:0] postSeg3
);

  localparam logic [7:0] c_last_sec = 8'(POST_SECONDS - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] sec_q,   sec_d;

  // Binary to three BCD digits by compare/subtract: {hundreds, tens, ones}
  function automatic logic [11:0] bin_to_bcd(input logic [7:0] v);
    logic [7:0] r;
    logic [3:0] h;
    logic [3:0] t;
    r = v;
    h = 4'd0;
    t = 4'd0;
    if (r >= 8'd200) begin
      h = 4'd2;
      r = r - 8'd200;
    end else if (r >= 8'd100) begin
      h = 4'd1;
      r = r - 8'd100;
    end
    for (int i = 0; i < 9; i++) begin
      if (r >= 8'd10) begin
        t = t + 4'd1;
        r = r - 8'd10;
      end
    end
    return {h, t, r[3:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sec_d   = sec_q;
    case (state_q)
      ST_IDLE: begin
        // A coincident Clk1Hz tick is deliberately not counted here
        if (postSig) begin
          count_d = magicSymbolCount;
          sec_d   = 8'd0;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (Clk1Hz) begin
          if (sec_q == c_last_sec) begin
            state_d = ST_DONE;
          end else begin
            sec_d = sec_q + 8'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk100M or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      count_q <= 8'd0;
      sec_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sec_q   <= sec_d;
    end
  end

  // DONE lasts exactly one cycle, so decoding it yields the registered pulse
  assign levelComplete = (state_q == ST_DONE);

  logic [11:0] bcd_w;
  logic        show_w;
  logic        blank0_w;
  logic        blank1_w;
  logic        blank2_w;

  assign bcd_w    = bin_to_bcd(count_q);
  assign show_w   = (state_q == ST_SHOW) || (state_q == ST_DONE);
  // Leading-zero suppression; the ones digit is always shown
  assign blank0_w = !show_w;
  assign blank1_w = !show_w || ((bcd_w[11:8] == 4'd0) && (bcd_w[7:4] == 4'd0));
  assign blank2_w = !show_w || (bcd_w[11:8] == 4'd0);

  seven_seg_decoder u_dec_ones (
    .bcd_i   (bcd_w[3:0]),
    .blank_i (blank0_w),
    .seg_o   (postSeg0)
  );

  seven_seg_decoder u_dec_tens (
    .bcd_i   (bcd_w[7:4]),
    .blank_i (blank1_w),
    .seg_o   (postSeg1)
  );

  seven_seg_decoder u_dec_hund (
    .bcd_i   (bcd_w[11:8]),
    .blank_i (blank2_w),
    .seg_o   (postSeg2)
  );

  assign postSeg3 = SEG_BLANK;

endmodule
`default_nettype wire

// File: tb/tb_post_period.sv
`default_nettype none
// ============================================================================
//  Module      : tb_post_period
//  Description : Scoreboard bench for post_period. The stimulus side decides,
//                from the tick schedule it drives, on which edge the period
//                must end and pushes that expectation; a monitor pops one
//                entry per levelComplete pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_post_period;

  localparam int NSEC = 5;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       post;
  logic [7:0] magic;
  logic       lc;
  logic [7:0] seg0, seg1, seg2, seg3;

  post_period #(.POST_SECONDS(NSEC)) dut (
    .Clk100M          (clk),
    .Reset            (rst),
    .Clk1Hz           (tick),
    .postSig          (post),
    .magicSymbolCount (magic),
    .levelComplete    (lc),
    .postSeg0         (seg0),
    .postSeg1         (seg1),
    .postSeg2         (seg2),
    .postSeg3         (seg3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         end_edge;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];

  logic [7:0] dig_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Expected display {seg3,seg2,seg1,seg0} for a decimal value
  function automatic logic [31:0] exp_disp(input int val);
    logic [7:0] s0, s1, s2;
    s0 = dig_tbl[val % 10];
    s1 = (val < 10)  ? 8'hFF : dig_tbl[(val / 10) % 10];
    s2 = (val < 100) ? 8'hFF : dig_tbl[val / 100];
    return {8'hFF, s2, s1, s0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%08h required=%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every levelComplete pulse must match the oldest expectation
  logic blank_next = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (blank_next) begin
        chk("blank_after_done", {seg3, seg2, seg1, seg0}, 32'hFFFFFFFF);
        blank_next = 1'b0;
      end
      if (lc) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_levelComplete", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("done_edge", cyc, e.end_edge);
          chk("done_disp", {seg3, seg2, seg1, seg0}, exp_disp(e.val));
          blank_next = 1'b1;
        end
      end
    end
  end

  // Drive one cycle of inputs; returns #1 after the edge that sampled them
  task automatic step(input logic p, input logic t, input logic [7:0] m);
    post  = p;
    tick  = t;
    magic = m;
    @(posedge clk);
    #1;
  endtask

  // One post period. gap: cycles between ticks; coinc: tick on the postSig
  // edge (must be ignored); disturb: spurious postSig / count changes in SHOW
  // and a postSig in the DONE cycle.
  task automatic run_period(input int val, input int gap, input bit coinc, input bit disturb);
    int  ticks;
    int  i;
    bit  t;
    bit  p;
    logic [7:0] m;
    step(1'b1, coinc, 8'(val));
    chk("disp_at_latch", {seg3, seg2, seg1, seg0}, exp_disp(val));
    ticks = 0;
    i     = 0;
    while (ticks < NSEC && i < 20000) begin
      i++;
      t = (i % gap) == 0;
      p = disturb && (i == 2);
      m = disturb ? ((i == 2) ? 8'd99 : 8'd3) : 8'($urandom_range(0, 255));
      step(p, t, m);
      if (t) ticks++;
      if (ticks == NSEC) sb_q.push_back('{end_edge: cyc, val: 8'(val)});
      if (p) chk("disp_hold", {seg3, seg2, seg1, seg0}, exp_disp(val));
    end
    // postSig in the DONE cycle must be ignored
    step(disturb, 1'b0, 8'd42);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
    chk("sb_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    tick  = 1'b0;
    post  = 1'b0;
    magic = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_disp", {seg3, seg2, seg1, seg0}, 32'hFFFFFFFF);
    chk("reset_lc", {31'd0, lc}, 32'd0);
    rst = 1'b0;

    // Idle: ticks but no postSig
    for (int i = 1; i <= 300; i++) begin
      step(1'b0, (i % 100) == 0, 8'($urandom_range(0, 255)));
      if (i % 50 == 0) chk("idle_disp", {seg3, seg2, seg1, seg0}, 32'hFFFFFFFF);
    end

    // Directed values
    run_period(27,  100, 1'b0, 1'b0);
    run_period(255, 100, 1'b0, 1'b0);
    run_period(0,   100, 1'b0, 1'b0);
    run_period(105, 100, 1'b0, 1'b0);
    run_period(64,  100, 1'b0, 1'b1);
    run_period(9,   100, 1'b1, 1'b0);

    // Reset in the middle of SHOW
    step(1'b1, 1'b0, 8'd77);
    for (int i = 1; i <= 250; i++) step(1'b0, (i % 100) == 0, 8'd77);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_disp", {seg3, seg2, seg1, seg0}, 32'hFFFFFFFF);
    chk("midreset_lc", {31'd0, lc}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 600; i++) step(1'b0, (i % 100) == 0, 8'd77);
    chk("post_reset_disp", {seg3, seg2, seg1, seg0}, 32'hFFFFFFFF);

    // Randomized periods
    for (int n = 0; n < 10; n++) begin
      run_period($urandom_range(0, 255), $urandom_range(1, 40),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/post_period.md
Name: post_period

Overview:
- End-of-level "post period" block for the symbol-counter game.
- A one-cycle postSig pulse latches the final magic-symbol count.
- The count is shown in decimal on four 7-segment digit patterns for POST_SECONDS ticks of the 1 Hz enable, then levelComplete pulses once so the top-level FSM can advance to the next level.
- Sits between the game-play controller and the display multiplexer.

Parameters:
- POST_SECONDS, 5, number of Clk1Hz ticks the count stays on display (legal range 1..255).

Ports:
- Clk100M  in  1  system clock, 100 MHz; all logic is on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Clk1Hz  in  1  one-Clk100M-cycle enable pulse, once per second; not a clock.
- postSig  in  1  one-cycle start pulse for the post period.
- magicSymbolCount  in  8  unsigned count to display, 0..255.
- levelComplete  out  1  one-cycle pulse when the post period ends.
- postSeg0  out  8  ones digit pattern.
- postSeg1  out  8  tens digit pattern.
- postSeg2  out  8  hundreds digit pattern.
- postSeg3  out  8  leftmost digit; always blank.

Behaviour:
- Interface: one clock (Clk100M); reset is asynchronous and active-high (Reset).
- Segment encoding is active-low {dp,g,f,e,d,c,b,a}; dp is always off (1).
  - Blank = 8'hFF.
  - Digits 0-9 = C0,F9,A4,B0,99,92,82,F8,80,90.
- Reset:
  - state=IDLE, latched count=0, second counter=0.
  - levelComplete=0, all postSeg=8'hFF.
- States: IDLE, SHOW, DONE.
- IDLE:
  - All postSeg are blank and levelComplete=0.
  - On postSig=1: latch magicSymbolCount, clear the second counter, go to SHOW.
  - A Clk1Hz tick in the same cycle as postSig is not counted.
- SHOW:
  - Display the latched count in decimal. Conversion is combinational from the latched register, so digits are valid from the clock edge that samples postSig.
  - Leading-zero suppression:
    - postSeg2 is blank if hundreds=0.
    - postSeg1 is blank if hundreds=0 and tens=0.
    - postSeg0 is always shown, so 0 displays as "0".
  - On each Clk1Hz=1: if the counter equals POST_SECONDS-1, go to DONE; otherwise increment the counter.
  - postSig in SHOW is ignored: no relatch, no restart.
  - magicSymbolCount changes after the latch have no effect.
- DONE:
  - levelComplete=1 for exactly this one cycle; digits still show the count.
  - Next cycle: IDLE, so displays blank.
  - postSig in DONE is ignored.
- Timing: SHOW lasts from the postSig edge until the POST_SECONDS-th tick after it. levelComplete is registered and asserts on the edge after that tick.
- Reset asserted mid-SHOW: immediate return to IDLE, outputs blank, no levelComplete pulse.
- Binary-to-BCD: 8-bit to 3 BCD digits (double-dabble or compare/subtract), purely combinational, with no extra latency.

Decomposition:
- Shared package: the state enum, segment constants SEG_BLANK (8'hFF), the digit table, and the default POST_SECONDS.
- One sub-module is natural: seven_seg_decoder (4-bit BCD plus blank flag in, 8-bit active-low pattern out), instantiated three times.
- The BCD conversion stays inline as a function.

Test Plan:
- Reset, then idle with no postSig for 300 cycles (Clk1Hz every 100 cycles) -> all postSeg=FF, levelComplete=0.
- postSig pulse with magicSymbolCount=27, Clk1Hz every 100 cycles -> postSeg0=F8, postSeg1=A4, postSeg2=FF, postSeg3=FF.
  - levelComplete is a single-cycle pulse right after the 5th tick, about 500 cycles later.
  - Displays return to FF the next cycle.
- Count=255 -> A4,92,92 on Seg2,Seg1,Seg0.
- Count=0 -> Seg0=C0, others FF.
- Count=105 -> Seg2=F9, Seg1=C0 (interior zero shown), Seg0=92.
- In SHOW, a second postSig with count=99, plus count changed to 3 -> display stays on the original value and the period is not extended.
- postSig coincident with a Clk1Hz tick -> that tick is not counted.
- Reset mid-SHOW -> outputs FF immediately and no levelComplete.
